// File: rtl/psg_write_sequencer_pkg.sv
// Shared types and byte encoders for the PSG write sequencer.
// The encoders map a note command onto SN76489 latch/data bytes.
package psg_write_sequencer_pkg;

    localparam logic [1:0] NOISE_CH = 2'd3;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD,
        WR_ASSERT,
        WR_RELEASE
    } seq_state_t;

    typedef enum logic [1:0] {
        KIND_TONE = 2'd0,
        KIND_VOL  = 2'd1,
        KIND_BOTH = 2'd2,
        KIND_RSVD = 2'd3
    } cmd_kind_t;

    typedef struct packed {
        logic [1:0] ch;
        cmd_kind_t  kind;
        logic [9:0] tone;
        logic [3:0] vol;
    } psg_cmd_t;

    // The noise channel has no data byte; its latch carries FB/NF1/NF0.
    function automatic logic [7:0] latch_tone_byte(input logic [1:0] ch, input logic [9:0] tone);
        if (ch == NOISE_CH)
            return {1'b1, NOISE_CH, 2'b00, tone[2:0]};
        return {1'b1, ch, 1'b0, tone[3:0]};
    endfunction

    function automatic logic [7:0] data_tone_byte(input logic [9:0] tone);
        return {2'b00, tone[9:4]};
    endfunction

    function automatic logic [7:0] vol_byte(input logic [1:0] ch, input logic [3:0] vol);
        return {1'b1, ch, 1'b1, vol};
    endfunction

    function automatic logic [1:0] byte_count(input psg_cmd_t cmd);
        logic [1:0] tone_bytes;
        tone_bytes = (cmd.ch == NOISE_CH) ? 2'd1 : 2'd2;
        case (cmd.kind)
            KIND_TONE: return tone_bytes;
            KIND_VOL:  return 2'd1;
            KIND_BOTH: return tone_bytes + 2'd1;
            default:   return 2'd0;
        endcase
    endfunction

    // Byte idx of a command: tone latch, tone data (not for noise), then volume.
    function automatic logic [7:0] cmd_byte(input psg_cmd_t cmd, input logic [1:0] idx);
        if (cmd.kind == KIND_VOL)
            return vol_byte(cmd.ch, cmd.vol);
        if (idx == 2'd0)
            return latch_tone_byte(cmd.ch, cmd.tone);
        if (idx == 2'd1 && cmd.ch != NOISE_CH)
            return data_tone_byte(cmd.tone);
        return vol_byte(cmd.ch, cmd.vol);
    endfunction

endpackage

// File: rtl/psg_write_sequencer_if.sv
// Command port plus PSG chip bus of the write sequencer.
interface psg_write_sequencer_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_CH;
    logic [1:0] CMD_KIND;
    logic [9:0] CMD_TONE;
    logic [3:0] CMD_VOL;
    logic [7:0] D;
    logic       nWE;
    logic       nCE;
    logic       READY;

    modport master (
        output CMD_VALID, CMD_CH, CMD_KIND, CMD_TONE, CMD_VOL, READY,
        input  CMD_READY, D, nWE, nCE
    );

    modport slave (
        input  CMD_VALID, CMD_CH, CMD_KIND, CMD_TONE, CMD_VOL, READY,
        output CMD_READY, D, nWE, nCE
    );
endinterface

// File: rtl/psg_write_sequencer_fifo.sv
// Synchronous command FIFO with registered read; pop_data holds until the next pop.
module psg_write_sequencer_fifo
    import psg_write_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  psg_cmd_t                 push_data,
    input  logic                     pop,
    output psg_cmd_t                 pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    psg_cmd_t      mem [DEPTH];
    psg_cmd_t      pop_data_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            pop_data_reg <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop) begin
                pop_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = pop_data_reg;
    assign count    = count_reg;
endmodule

// File: rtl/psg_write_sequencer.sv
// Serialises buffered note commands into SN76489 bus writes with READY handshake
// and an optional power-up mute of all four channels.
module psg_write_sequencer
    import psg_write_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int READY_TIMEOUT = 255,
    parameter int INIT_MUTE     = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    psg_write_sequencer_if.slave         bus,
    output logic                         BUSY,
    output logic                         ERR_TIMEOUT,
    input  logic                         ERR_CLR,
    output logic [$clog2(FIFO_DEPTH):0]  FIFO_COUNT
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (READY_TIMEOUT < 2) ? 1 : $clog2(READY_TIMEOUT);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(READY_TIMEOUT - 1);

    seq_state_t    state_reg, state_next;
    psg_cmd_t      cmd_in, cmd_cur;
    logic          fifo_full, fifo_empty, cmd_push, cmd_pop;
    logic [CW-1:0] fifo_count, count_next;
    logic [7:0]    d_reg, cur_byte;
    logic          nwe_reg, cmd_ready_reg, err_reg;
    logic [1:0]    byte_idx_reg, init_ch_reg;
    logic          init_active_reg, init_active_next;
    logic [TW-1:0] wait_cnt_reg;
    logic          byte_avail, load_byte, timeout_hit, init_step;

    assign cmd_in   = '{ch: bus.CMD_CH, kind: cmd_kind_t'(bus.CMD_KIND),
                        tone: bus.CMD_TONE, vol: bus.CMD_VOL};
    assign cmd_push = bus.CMD_VALID && cmd_ready_reg && !fifo_full;

    psg_write_sequencer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLK),
        .srst      (RST),
        .push      (cmd_push),
        .push_data (cmd_in),
        .pop       (cmd_pop),
        .pop_data  (cmd_cur),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // During the mute phase the byte source is the channel counter, not the FIFO.
    assign byte_avail = (byte_idx_reg < byte_count(cmd_cur));
    assign cur_byte   = init_active_reg ? vol_byte(init_ch_reg, 4'hF)
                                        : cmd_byte(cmd_cur, byte_idx_reg);

    always_ff @(posedge CLK) begin
        if (RST)
            state_reg <= (INIT_MUTE != 0) ? INIT : IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            INIT:       state_next = LOAD;
            IDLE:       if (!fifo_empty) state_next = LOAD;
            LOAD:       state_next = (init_active_reg || byte_avail) ? WR_ASSERT : IDLE;
            WR_ASSERT:  if (!bus.READY || timeout_hit) state_next = WR_RELEASE;
            WR_RELEASE: begin
                if (bus.READY) begin
                    if (init_active_reg)
                        state_next = (init_ch_reg == 2'd3) ? IDLE : LOAD;
                    else
                        state_next = byte_avail ? LOAD : IDLE;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_pop          = (state_reg == IDLE) && !fifo_empty;
        load_byte        = (state_reg == LOAD) && (init_active_reg || byte_avail);
        timeout_hit      = (state_reg == WR_ASSERT) && bus.READY && (wait_cnt_reg == TIMEOUT_LAST);
        init_step        = (state_reg == WR_RELEASE) && bus.READY && init_active_reg;
        init_active_next = init_active_reg && !(init_step && init_ch_reg == 2'd3);
        count_next       = fifo_count + CW'(cmd_push) - CW'(cmd_pop);
    end

    // nWE follows the state one cycle late, so a push into an idle empty FIFO
    // drives the bus low on the third edge after it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            d_reg           <= '0;
            nwe_reg         <= 1'b1;
            cmd_ready_reg   <= 1'b0;
            err_reg         <= 1'b0;
            byte_idx_reg    <= '0;
            init_ch_reg     <= '0;
            init_active_reg <= (INIT_MUTE != 0);
            wait_cnt_reg    <= '0;
        end else begin
            nwe_reg         <= (state_reg != WR_ASSERT);
            cmd_ready_reg   <= (count_next != CW'(FIFO_DEPTH)) && !init_active_next;
            init_active_reg <= init_active_next;
            if (cmd_pop)
                byte_idx_reg <= '0;
            if (load_byte) begin
                d_reg        <= cur_byte;
                wait_cnt_reg <= '0;
                if (!init_active_reg)
                    byte_idx_reg <= byte_idx_reg + 1'b1;
            end else if (state_reg == WR_ASSERT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            // Pushing the index past any byte count drops the rest of the command.
            if (timeout_hit)
                byte_idx_reg <= 2'd3;
            if (init_step)
                init_ch_reg <= init_ch_reg + 1'b1;
            if (timeout_hit)
                err_reg <= 1'b1;
            else if (ERR_CLR)
                err_reg <= 1'b0;
        end
    end

    assign bus.D         = d_reg;
    assign bus.nWE       = nwe_reg;
    assign bus.nCE       = nwe_reg;
    assign bus.CMD_READY = cmd_ready_reg;
    assign BUSY          = !fifo_empty || (state_reg != IDLE);
    assign ERR_TIMEOUT   = err_reg;
    assign FIFO_COUNT    = fifo_count;
endmodule

// File: tb/tb_psg_write_sequencer.sv
// Scoreboard bench: expected PSG bytes are queued with each command and compared
// against the bytes captured on every nWE falling edge.
module tb_psg_write_sequencer;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic       busy, err_timeout;
    logic [3:0] fifo_count;

    psg_write_sequencer_if bus();

    psg_write_sequencer #(
        .FIFO_DEPTH(DEPTH), .READY_TIMEOUT(TMO), .INIT_MUTE(1)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus), .BUSY(busy),
        .ERR_TIMEOUT(err_timeout), .ERR_CLR(err_clr), .FIFO_COUNT(fifo_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         ce_bad = 0;
    int         chk_idx = 0;
    int         ready_mode = 0;   // 0: READY held high, 1: held low, 2: 2-cycle low pulse per write
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // PSG model: owns READY.
    initial begin
        bus.READY = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_mode == 0) bus.READY = 1'b1;
            else if (ready_mode == 1) bus.READY = 1'b0;
            else if (bus.nWE == 1'b0) begin
                bus.READY = 1'b0;
                repeat (2) @(negedge clk);
                bus.READY = 1'b1;
                for (int k = 0; k < 64 && bus.nWE == 1'b0; k++) @(negedge clk);
            end else bus.READY = 1'b1;
        end
    end

    // Bus monitor: one captured byte per nWE falling edge.
    initial begin
        logic prev_nwe;
        prev_nwe = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_nwe === 1'b1 && bus.nWE === 1'b0) got_q.push_back(bus.D);
            if (bus.nCE !== bus.nWE) ce_bad++;
            prev_nwe = bus.nWE;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, writes=%0d required %0d", got_q.size(), exp_q.size());
        $fatal(1);
    end

    task automatic push_cmd(input logic [1:0] ch, input logic [1:0] kind,
                            input logic [9:0] tone, input logic [3:0] vol);
        int w;
        w = 0;
        @(negedge clk);
        while (bus.CMD_READY !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            n_checks++; n_fail++;
            $display("FAIL push_wait: CMD_READY=%b required 1", bus.CMD_READY);
        end
        bus.CMD_CH = ch; bus.CMD_KIND = kind; bus.CMD_TONE = tone; bus.CMD_VOL = vol;
        bus.CMD_VALID = 1'b1;
        @(posedge clk); #1;
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(got_q.size() >= exp_q.size() && busy === 1'b0 && bus.nWE === 1'b1) && w < budget);
        if (w >= budget) begin
            n_checks++; n_fail++;
            $display("FAIL idle_wait: BUSY=%b writes=%0d required BUSY=0 writes=%0d",
                     busy, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset;
        ready_mode = 2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.D !== 8'h00) begin n_fail++; $display("FAIL reset_D: got %02h required 00", bus.D); end
        n_checks++; if (bus.nWE !== 1'b1 || bus.nCE !== 1'b1) begin n_fail++; $display("FAIL reset_nWE_nCE: got %b%b required 11", bus.nWE, bus.nCE); end
        n_checks++; if (bus.CMD_READY !== 1'b0) begin n_fail++; $display("FAIL reset_CMD_READY: got %b required 0", bus.CMD_READY); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_BUSY: got %b required 1", busy); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_ERR: got %b required 0", err_timeout); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_FIFO_COUNT: got %0d required 0", fifo_count); end
        exp_q.push_back(8'h9F); exp_q.push_back(8'hBF); exp_q.push_back(8'hDF); exp_q.push_back(8'hFF);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.CMD_READY !== 1'b0) begin n_fail++; $display("FAIL init_CMD_READY: got %b required 0", bus.CMD_READY); end
        wait_idle(400);
        while (chk_idx < exp_q.size()) begin
            n_checks++;
            if (chk_idx >= got_q.size()) begin n_fail++; $display("FAIL mute_byte[%0d]: no write, required %02h", chk_idx, exp_q[chk_idx]); end
            else if (got_q[chk_idx] !== exp_q[chk_idx]) begin n_fail++; $display("FAIL mute_byte[%0d]: got %02h required %02h", chk_idx, got_q[chk_idx], exp_q[chk_idx]); end
            chk_idx++;
        end
        @(negedge clk);
        n_checks++; if (bus.CMD_READY !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mute_done: CMD_READY=%b BUSY=%b required 1 0", bus.CMD_READY, busy); end
    endtask

    task automatic test_tone_vol;
        int base;
        base = got_q.size();
        exp_q.push_back(8'h8E); exp_q.push_back(8'h0F); exp_q.push_back(8'h91);
        push_cmd(2'd0, 2'd2, 10'h0FE, 4'h1);
        @(posedge clk); #1;
        n_checks++; if (bus.nWE !== 1'b1) begin n_fail++; $display("FAIL latency_e1: nWE=%b required 1", bus.nWE); end
        @(posedge clk); #1;
        n_checks++; if (bus.nWE !== 1'b1) begin n_fail++; $display("FAIL latency_e2: nWE=%b required 1", bus.nWE); end
        @(posedge clk); #1;
        n_checks++; if (bus.nWE !== 1'b0) begin n_fail++; $display("FAIL latency_e3: nWE=%b required 0", bus.nWE); end
        wait_idle(400);
        n_checks++; if (got_q.size() - base !== 3) begin n_fail++; $display("FAIL both_pulses: got %0d required 3", got_q.size() - base); end
        while (chk_idx < exp_q.size()) begin
            n_checks++;
            if (chk_idx >= got_q.size()) begin n_fail++; $display("FAIL both_byte[%0d]: no write, required %02h", chk_idx, exp_q[chk_idx]); end
            else if (got_q[chk_idx] !== exp_q[chk_idx]) begin n_fail++; $display("FAIL both_byte[%0d]: got %02h required %02h", chk_idx, got_q[chk_idx], exp_q[chk_idx]); end
            chk_idx++;
        end
    endtask

    task automatic test_noise;
        int base;
        base = got_q.size();
        exp_q.push_back(8'hE5);
        push_cmd(2'd3, 2'd0, 10'b11_1111_1101, 4'h0);
        wait_idle(400);
        repeat (4) @(negedge clk);
        n_checks++; if (got_q.size() - base !== 1) begin n_fail++; $display("FAIL noise_pulses: got %0d required 1", got_q.size() - base); end
        while (chk_idx < exp_q.size()) begin
            n_checks++;
            if (chk_idx >= got_q.size()) begin n_fail++; $display("FAIL noise_byte: no write, required %02h", exp_q[chk_idx]); end
            else if (got_q[chk_idx] !== exp_q[chk_idx]) begin n_fail++; $display("FAIL noise_byte: got %02h required %02h", got_q[chk_idx], exp_q[chk_idx]); end
            chk_idx++;
        end
    endtask

    task automatic test_timeout;
        int base, w, low;
        base = got_q.size();
        ready_mode = 0;
        exp_q.push_back(8'hA3);
        push_cmd(2'd1, 2'd2, 10'h123, 4'h5);
        w = 0; low = 0;
        while (w < 200) begin
            @(negedge clk);
            w++;
            if (bus.nWE === 1'b0) low++;
            else if (low > 0) break;
        end
        n_checks++; if (low !== TMO) begin n_fail++; $display("FAIL timeout_low_cycles: got %0d required %0d", low, TMO); end
        wait_idle(400);
        repeat (3) @(negedge clk);
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b required 1", err_timeout); end
        n_checks++; if (got_q.size() - base !== 1) begin n_fail++; $display("FAIL timeout_skip: writes %0d required 1", got_q.size() - base); end
        while (chk_idx < exp_q.size()) begin
            n_checks++;
            if (chk_idx >= got_q.size()) begin n_fail++; $display("FAIL timeout_byte: no write, required %02h", exp_q[chk_idx]); end
            else if (got_q[chk_idx] !== exp_q[chk_idx]) begin n_fail++; $display("FAIL timeout_byte: got %02h required %02h", got_q[chk_idx], exp_q[chk_idx]); end
            chk_idx++;
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b required 0", err_timeout); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] ch;
        logic [9:0] tone;
        logic [3:0] v;
        int w;
        ready_mode = 1;
        exp_q.push_back(8'h97);
        push_cmd(2'd0, 2'd1, 10'h000, 4'h7);
        w = 0;
        while (got_q.size() < exp_q.size() && w < 50) begin @(negedge clk); w++; end
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0) begin
                ch = 2'(i % 4); v = 4'(i);
                exp_q.push_back({1'b1, ch, 1'b1, v});
                push_cmd(ch, 2'd1, 10'h000, v);
            end else begin
                ch = 2'(i % 3); tone = 10'(i * 37 + 5);
                exp_q.push_back({1'b1, ch, 1'b0, tone[3:0]});
                exp_q.push_back({2'b00, tone[9:4]});
                push_cmd(ch, 2'd0, tone, 4'h0);
            end
        end
        @(negedge clk);
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d required 8", fifo_count); end
        n_checks++; if (bus.CMD_READY !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b required 0", bus.CMD_READY); end
        bus.CMD_CH = 2'd2; bus.CMD_KIND = 2'd1; bus.CMD_VOL = 4'h3; bus.CMD_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL overflow_count: got %0d required 8", fifo_count); end
        end
        bus.CMD_VALID = 1'b0;
        ready_mode = 2;
        wait_idle(2000);
        while (chk_idx < exp_q.size()) begin
            n_checks++;
            if (chk_idx >= got_q.size()) begin n_fail++; $display("FAIL drain_byte[%0d]: no write, required %02h", chk_idx, exp_q[chk_idx]); end
            else if (got_q[chk_idx] !== exp_q[chk_idx]) begin n_fail++; $display("FAIL drain_byte[%0d]: got %02h required %02h", chk_idx, got_q[chk_idx], exp_q[chk_idx]); end
            chk_idx++;
        end
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL drain_total: got %0d writes required %0d", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid_write;
        int w;
        ready_mode = 0;
        exp_q.push_back(8'hD3);
        push_cmd(2'd2, 2'd1, 10'h000, 4'h3);
        push_cmd(2'd0, 2'd1, 10'h000, 4'h0);
        w = 0;
        while (bus.nWE !== 1'b0 && w < 50) begin @(negedge clk); w++; end
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL pre_reset_count: got %0d required 1", fifo_count); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.nWE !== 1'b1 || bus.nCE !== 1'b1) begin n_fail++; $display("FAIL rst_release: nWE=%b nCE=%b required 1 1", bus.nWE, bus.nCE); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rst_flush: got %0d required 0", fifo_count); end
        n_checks++; if (bus.D !== 8'h00) begin n_fail++; $display("FAIL rst_D: got %02h required 00", bus.D); end
        exp_q.push_back(8'h9F); exp_q.push_back(8'hBF); exp_q.push_back(8'hDF); exp_q.push_back(8'hFF);
        ready_mode = 2;
        @(negedge clk); rst = 1'b0;
        wait_idle(400);
        while (chk_idx < exp_q.size()) begin
            n_checks++;
            if (chk_idx >= got_q.size()) begin n_fail++; $display("FAIL remute_byte[%0d]: no write, required %02h", chk_idx, exp_q[chk_idx]); end
            else if (got_q[chk_idx] !== exp_q[chk_idx]) begin n_fail++; $display("FAIL remute_byte[%0d]: got %02h required %02h", chk_idx, got_q[chk_idx], exp_q[chk_idx]); end
            chk_idx++;
        end
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL remute_total: got %0d writes required %0d", got_q.size(), exp_q.size()); end
        n_checks++; if (ce_bad !== 0) begin n_fail++; $display("FAIL nce_tracks_nwe: %0d differing cycles required 0", ce_bad); end
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_CH    = 2'd0;
        bus.CMD_KIND  = 2'd0;
        bus.CMD_TONE  = 10'd0;
        bus.CMD_VOL   = 4'd0;
        test_reset();
        test_tone_vol();
        test_noise();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
